// File: rtl/prbs5_checker.sv
// Receive-side checker for the x^5+x^3+1 PRBS stream.
// Self-synchronises, then flywheels and counts bit errors while locked.
module prbs5_checker #(
    parameter int CNT_W       = 16,
    parameter int VERIFY_LEN  = 8,
    parameter int WIN_LEN     = 32,
    parameter int LOSS_THRESH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    input  logic             in_bit,
    output logic             locked,
    output logic             err,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] bit_cnt
);

    localparam int GW  = $clog2(VERIFY_LEN + 1);
    localparam int WCW = $clog2(WIN_LEN + 1);
    localparam int EMX = (WIN_LEN > LOSS_THRESH) ? WIN_LEN : LOSS_THRESH;
    localparam int EW  = $clog2(EMX + 1);

    localparam logic [GW-1:0]    GOOD_MAX = GW'(VERIFY_LEN);
    localparam logic [WCW-1:0]   WIN_LAST = WCW'(WIN_LEN - 1);
    localparam logic [EW-1:0]    LOSS_N   = EW'(LOSS_THRESH);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        SEARCH,
        VERIFY,
        LOCKED
    } state_t;

    state_t           state, state_n;
    logic [4:0]       sh, sh_n;
    logic [2:0]       fill, fill_n;
    logic [GW-1:0]    good, good_n;
    logic [WCW-1:0]   win_cnt, win_cnt_n;
    logic [EW-1:0]    win_err, win_err_n;
    logic             err_n;
    logic [CNT_W-1:0] err_cnt_n, bit_cnt_n;
    logic             p;
    logic             miss;

    assign p      = sh[2] ^ sh[4];
    assign miss   = in_bit ^ p;
    assign locked = (state == LOCKED);

    always_comb begin
        state_n   = state;
        sh_n      = sh;
        fill_n    = fill;
        good_n    = good;
        win_cnt_n = win_cnt;
        win_err_n = win_err;
        err_n     = 1'b0;
        err_cnt_n = err_cnt;
        bit_cnt_n = bit_cnt;
        if (in_valid) begin
            unique case (state)
                SEARCH: begin
                    sh_n = {sh[3:0], in_bit};
                    if (fill != 3'd5)
                        fill_n = fill + 3'd1;
                    // all-zero register is the LFSR dead state: keep searching
                    if (fill_n == 3'd5 && sh_n != 5'd0) begin
                        state_n = VERIFY;
                        good_n  = '0;
                    end
                end
                VERIFY: begin
                    sh_n = {sh[3:0], in_bit};
                    if (!miss) begin
                        good_n = good + GW'(1);
                        if (good_n == GOOD_MAX) begin
                            state_n   = LOCKED;
                            win_cnt_n = '0;
                            win_err_n = '0;
                        end
                    end else begin
                        state_n = SEARCH;
                        fill_n  = 3'd1;
                    end
                end
                LOCKED: begin
                    sh_n = {sh[3:0], p};
                    if (bit_cnt != CNT_MAX)
                        bit_cnt_n = bit_cnt + CNT_W'(1);
                    if (miss) begin
                        err_n     = 1'b1;
                        win_err_n = win_err + EW'(1);
                        if (err_cnt != CNT_MAX)
                            err_cnt_n = err_cnt + CNT_W'(1);
                    end
                    if (miss && win_err_n == LOSS_N) begin
                        state_n = SEARCH;
                        fill_n  = 3'd0;
                        sh_n    = sh;
                    end else if (win_cnt == WIN_LAST) begin
                        win_cnt_n = '0;
                        win_err_n = '0;
                    end else begin
                        win_cnt_n = win_cnt + WCW'(1);
                    end
                end
                default: state_n = SEARCH;
            endcase
        end
        if (clr) begin
            err_cnt_n = '0;
            bit_cnt_n = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= SEARCH;
            sh      <= 5'd0;
            fill    <= 3'd0;
            good    <= '0;
            win_cnt <= '0;
            win_err <= '0;
            err     <= 1'b0;
            err_cnt <= '0;
            bit_cnt <= '0;
        end else begin
            state   <= state_n;
            sh      <= sh_n;
            fill    <= fill_n;
            good    <= good_n;
            win_cnt <= win_cnt_n;
            win_err <= win_err_n;
            err     <= err_n;
            err_cnt <= err_cnt_n;
            bit_cnt <= bit_cnt_n;
        end
    end

endmodule

// File: tb/tb_prbs5_checker.sv
// Scoreboard bench for prbs5_checker: default instance plus a
// narrow-counter instance with loss-of-lock disabled.
module tb_prbs5_checker;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clr = 1'b0;
    logic va = 1'b0;
    logic vb = 1'b0;
    logic in_bit = 1'b0;

    logic        lk_a, er_a, lk_b, er_b;
    logic [15:0] ec_a, bc_a;
    logic [3:0]  ec_b, bc_b;

    prbs5_checker u_a (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(va), .in_bit(in_bit),
        .locked(lk_a), .err(er_a), .err_cnt(ec_a), .bit_cnt(bc_a)
    );

    prbs5_checker #(.CNT_W(4), .LOSS_THRESH(33)) u_b (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(vb), .in_bit(in_bit),
        .locked(lk_b), .err(er_b), .err_cnt(ec_b), .bit_cnt(bc_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic  sel;
        logic  lk;
        logic  er;
        int    ec;
        int    bc;
        string tag;
    } exp_t;

    exp_t  q[$];
    int    checks = 0;
    int    errors = 0;
    logic  sel = 1'b0;
    logic  m_lk = 1'b0;
    int    m_ec = 0;
    int    m_bc = 0;
    logic [4:0] g = 5'b00001;
    string phase = "reset";

    // one clock of stimulus; expected outputs after the next edge are queued
    task automatic step(input logic v, input logic b, input logic nlk,
                        input logic er, input logic c);
        exp_t e;
        int   mx;
        mx = sel ? 15 : 65535;
        @(negedge clk);
        va = v & ~sel;
        vb = v & sel;
        in_bit = b;
        clr = c;
        if (v) begin
            if (m_lk) begin
                if (m_bc < mx) m_bc++;
                if (er && m_ec < mx) m_ec++;
            end
            m_lk = nlk;
        end
        if (c) begin
            m_ec = 0;
            m_bc = 0;
        end
        e.sel = sel;
        e.lk  = m_lk;
        e.er  = v & er;
        e.ec  = m_ec;
        e.bc  = m_bc;
        e.tag = phase;
        q.push_back(e);
    endtask

    task automatic gb(input logic inv, input logic nlk, input logic er,
                      input logic c);
        logic b;
        b = g[2] ^ g[4];
        g = {g[3:0], b};
        step(1'b1, b ^ inv, nlk, er, c);
    endtask

    task automatic lock13();
        for (int i = 0; i < 13; i++)
            gb(1'b0, i == 12, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        va = 1'b0;
        vb = 1'b0;
        clr = 1'b0;
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        checks++;
        if (lk_a || er_a || ec_a != 0 || bc_a != 0) begin
            errors++;
            $display("FAIL %s dutA lk=%0b err=%0b ec=%0d bc=%0d, want all 0",
                     phase, lk_a, er_a, ec_a, bc_a);
        end
        checks++;
        if (lk_b || er_b || ec_b != 0 || bc_b != 0) begin
            errors++;
            $display("FAIL %s dutB lk=%0b err=%0b ec=%0d bc=%0d, want all 0",
                     phase, lk_b, er_b, ec_b, bc_b);
        end
        #1 rst = 1'b1;
        m_lk = 1'b0;
        m_ec = 0;
        m_bc = 0;
    endtask

    initial begin : monitor
        exp_t e;
        logic alk, aer;
        int   aec, abc;
        forever begin
            @(posedge clk);
            if (q.size() > 0) begin
                #1;
                e = q.pop_front();
                if (e.sel) begin
                    alk = lk_b; aer = er_b;
                    aec = int'(ec_b); abc = int'(bc_b);
                end else begin
                    alk = lk_a; aer = er_a;
                    aec = int'(ec_a); abc = int'(bc_a);
                end
                checks++;
                if (alk !== e.lk || aer !== e.er || aec != e.ec || abc != e.bc) begin
                    errors++;
                    $display("FAIL %s dut%0d got lk=%0b err=%0b ec=%0d bc=%0d want lk=%0b err=%0b ec=%0d bc=%0d",
                             e.tag, e.sel, alk, aer, aec, abc,
                             e.lk, e.er, e.ec, e.bc);
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        errors++;
        $display("FAIL watchdog sim time expired, queue=%0d", q.size());
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : stim
        #1 rst = 1'b0;
        do_reset();

        phase = "T1_lock";
        lock13();
        phase = "T1_run";
        for (int i = 0; i < 100; i++)
            gb(1'b0, 1'b1, 1'b0, 1'b0);

        phase = "T2_flip";
        gb(1'b1, 1'b1, 1'b1, 1'b0);
        phase = "T2_clean";
        for (int i = 0; i < 31; i++)
            gb(1'b0, 1'b1, 1'b0, 1'b0);

        phase = "T3_clr";
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        phase = "T3_flips";
        for (int k = 0; k < 7; k++)
            gb(k % 2 == 0, k != 6, k % 2 == 0, 1'b0);
        phase = "T3_relock";
        lock13();
        for (int i = 0; i < 5; i++)
            gb(1'b0, 1'b1, 1'b0, 1'b0);

        phase = "T4_rst";
        do_reset();
        phase = "T4_zeros";
        for (int i = 0; i < 200; i++)
            step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        phase = "T6_rst";
        do_reset();
        phase = "T6_lock";
        lock13();
        for (int i = 0; i < 10; i++)
            gb(1'b0, 1'b1, 1'b0, 1'b0);
        phase = "T6_midrst";
        do_reset();
        phase = "T6_relock";
        lock13();
        for (int i = 0; i < 5; i++)
            gb(1'b0, 1'b1, 1'b0, 1'b0);

        sel = 1'b1;
        m_lk = 1'b0;
        m_ec = 0;
        m_bc = 0;
        phase = "T5_lock";
        lock13();
        phase = "T5_sat";
        for (int i = 0; i < 80; i++)
            gb(i % 4 == 3, 1'b1, i % 4 == 3, 1'b0);
        phase = "T5_clr";
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        phase = "T5_clr_beats";
        gb(1'b1, 1'b1, 1'b1, 1'b1);
        phase = "T5_gaps";
        for (int i = 0; i < 12; i++) begin
            while ($urandom_range(0, 2) == 0)
                step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            gb(i % 4 == 3, 1'b1, i % 4 == 3, 1'b0);
        end
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        @(negedge clk);
        va = 1'b0;
        vb = 1'b0;
        clr = 1'b0;
        @(posedge clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain queue=%0d, want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
